// File: rtl/stripes_bitserial_ctrl.sv
// stripes_bitserial_ctrl: sequences one bit-serial 16-lane MAC job, LSB column first, and accumulates the dot product
module stripes_bitserial_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 16,
  parameter int IDX_WIDTH    = $clog2(DATA_WIDTH),
  parameter int RESULT_WIDTH = 3*DATA_WIDTH,
  parameter int ACC_WIDTH    = DATA_WIDTH+16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_act,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_weight,
  input  logic [ACC_WIDTH-1:0]                   in_bias,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  mac_act,
  output logic [VEC_LENGTH-1:0]                  mac_w_bit,
  output logic [IDX_WIDTH-1:0]                   mac_column_idx,
  output logic                                   mac_is_msb,
  output logic                                   mac_en,
  input  logic [RESULT_WIDTH-1:0]                mac_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_WIDTH-1:0]                   out_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(DATA_WIDTH-1);
  state_t state, state_nxt;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_q;
  logic [IDX_WIDTH-1:0] k;
  logic [ACC_WIDTH-1:0] acc;
  logic acc_en;
  always_comb begin
    state_nxt      = state;
    in_ready       = state == IDLE;
    mac_en         = state == RUN;
    out_valid      = state == DONE;
    mac_is_msb     = state == RUN && k == K_LAST;
    mac_column_idx = k;
    out_data       = acc;
    case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = k == K_LAST ? DRAIN : RUN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // k parks on the last column after a job so mac_w_bit holds its final value
  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_wbit
    assign mac_w_bit[j] = weight_q[j][k];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mac_act  <= '0;
      weight_q <= '0;
      k        <= '0;
      acc      <= '0;
      acc_en   <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc_en <= mac_en;
      if (in_valid && in_ready) begin
        mac_act  <= in_act;
        weight_q <= in_weight;
        acc      <= in_bias;
        k        <= '0;
      end else begin
        if (acc_en) acc <= acc + ACC_WIDTH'($signed(mac_result));
        if (mac_en && k != K_LAST) k <= k + IDX_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_stripes_bitserial_ctrl.sv
// tb_stripes_bitserial_ctrl: scoreboard bench with a behavioural bit-serial MAC beside the sequencer
module tb_stripes_bitserial_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0][7:0] in_act = '0;
  logic [15:0][7:0] in_weight = '0;
  logic [23:0] in_bias = '0;
  logic [15:0][7:0] mac_act;
  logic [15:0] mac_w_bit;
  logic [2:0] mac_column_idx;
  logic mac_is_msb, mac_en;
  logic [23:0] mac_result;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [23:0] out_data;
  int n_checks = 0;
  int n_fail = 0;
  longint exp_q[$];
  logic [15:0][7:0] ones, a127, wneg, aramp, w3;
  longint held;

  stripes_bitserial_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_weight(in_weight), .in_bias(in_bias),
    .mac_act(mac_act), .mac_w_bit(mac_w_bit), .mac_column_idx(mac_column_idx),
    .mac_is_msb(mac_is_msb), .mac_en(mac_en), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mac_calc(input logic [15:0][7:0] a, input logic [15:0] b,
                                           input logic [2:0] k, input logic msb);
    int s = 0;
    for (int j = 0; j < 16; j++) if (b[j]) s += int'($signed(a[j]));
    s = s <<< k;
    if (msb) s = -s;
    return 24'(s);
  endfunction

  always_ff @(posedge clk) if (mac_en) mac_result <= mac_calc(mac_act, mac_w_bit, mac_column_idx, mac_is_msb);

  task automatic chk(input string nm, input longint a, input longint e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", longint'($signed(out_data)), 0);
      else chk("out_data", longint'($signed(out_data)), exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_idx", mac_column_idx, 0);
    chk("rst_msb", mac_is_msb, 0);
    chk("rst_w_bit", mac_w_bit, 0);
    chk("rst_mac_act_zero", mac_act == '0, 1);
    chk("rst_out_data", out_data, 0);
  endtask

  task automatic send(input logic [15:0][7:0] a, input logic [15:0][7:0] w, input int b,
                      input longint e, input bit cols);
    logic [15:0] wb;
    in_act = a;
    in_weight = w;
    in_bias = 24'(b);
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !in_ready; n++) tick();
    chk("accept_ready", in_ready, 1);
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
    if (cols) begin
      for (int c = 0; c < 8; c++) begin
        for (int j = 0; j < 16; j++) wb[j] = w[j][c];
        chk("col_en", mac_en, 1);
        chk("col_idx", mac_column_idx, c);
        chk("col_msb", mac_is_msb, c == 7);
        chk("col_w_bit", mac_w_bit, wb);
        chk("col_in_ready", in_ready, 0);
        tick();
      end
      chk("drain_en", mac_en, 0);
      chk("drain_valid", out_valid, 0);
      tick();
      chk("latency_valid", out_valid, 1);
    end
  endtask

  task automatic wait_done;
    int n = 0;
    while (n < 60 && !out_valid) begin tick(); n++; end
    chk("done_seen", out_valid, 1);
    n = 0;
    while (n < 60 && out_valid) begin tick(); n++; end
    chk("done_released", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < 16; j++) begin
      ones[j] = 8'd1;
      a127[j] = 8'd127;
      wneg[j] = 8'h80;
      aramp[j] = 8'(j - 8);
      w3[j] = 8'd3;
    end
    tick();
    tick();
    chk_reset();
    reset = 1'b0;
    tick();
    // all ones: 16, msb only on the last column
    send(ones, ones, 0, 16, 1'b1);
    wait_done();
    // ramp acts with weight 3 plus bias: 100 + 3*(-8)
    send(aramp, w3, 100, 76, 1'b1);
    wait_done();
    // most negative weight with backpressure on the result
    out_ready = 1'b0;
    send(a127, wneg, 0, -260096, 1'b1);
    held = longint'($signed(out_data));
    chk("bp_data_value", held, -260096);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", longint'($signed(out_data)), held);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_released", out_valid, 0);
    chk("bp_in_ready_after", in_ready, 1);
    // reset in T5 of a job abandons it
    in_act = ones;
    in_weight = ones;
    in_bias = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_reset_running", mac_en, 1);
    reset = 1'b1;
    #1;
    chk_reset();
    tick();
    reset = 1'b0;
    tick();
    send(ones, ones, 0, 16, 1'b0);
    wait_done();
    // back-to-back jobs with in_valid held high
    in_act = ones;
    in_weight = ones;
    in_bias = '0;
    in_valid = 1'b1;
    chk("b2b_first_ready", in_ready, 1);
    exp_q.push_back(16);
    tick();
    in_act = aramp;
    in_weight = w3;
    in_bias = 24'd100;
    begin
      int n = 0;
      while (n < 60 && !out_valid) begin tick(); n++; end
    end
    chk("b2b_first_done", out_valid, 1);
    chk("b2b_not_ready_in_done", in_ready, 0);
    tick();
    chk("b2b_second_ready", in_ready, 1);
    exp_q.push_back(76);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_running", mac_en, 1);
    wait_done();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
